// File: rtl/iic_rd_word_packer_if.sv
// -----------------------------------------------------------------------------
// iic_rd_word_packer_if
// Bundles the two streams around the read-word packer:
//   byte side : byte_vld / byte_ready / byte_data  (I2C master read channel,
//               byte_ready is owned by the read sequencer and only observed)
//   word side : word_vld / word_ready / word_data / word_keep / word_last
// Modports:
//   slave  - the packer (observes bytes, sources words)
//   master - the environment (sources bytes, consumes words)
// -----------------------------------------------------------------------------
interface iic_rd_word_packer_if;
    logic        byte_vld;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        word_vld;
    logic        word_ready;
    logic [31:0] word_data;
    logic [3:0]  word_keep;
    logic        word_last;

    modport slave (
        input  byte_vld, byte_ready, byte_data, word_ready,
        output word_vld, word_data, word_keep, word_last
    );

    modport master (
        output byte_vld, byte_ready, byte_data, word_ready,
        input  word_vld, word_data, word_keep, word_last
    );
endinterface

// File: rtl/iic_rd_word_packer.sv
// -----------------------------------------------------------------------------
// iic_rd_word_packer
// Snoops accepted I2C read bytes, packs them into 32-bit words and buffers the
// words in a small FIFO presented to a host as a valid/ready stream.
//
// Ports:
//   clock, rst_n  - clock and synchronous active-low reset
//   start         - one-cycle pulse, begins a transaction (accepted in IDLE)
//   burst_len     - bytes expected, latched on an accepted start
//   bus (slave)   - byte snoop inputs and word stream outputs
//   busy          - transaction in progress
//   done          - one-cycle pulse once the transaction is fully drained
//   overflow      - sticky, a packed word was dropped on a full FIFO
//
// Build option: define IIC_PACK_BIG_ENDIAN_EN to place byte k of a word in
// bits [31-8k:24-8k] (keep[3-k]); default is little-endian.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start; bytes ignored
// COLLECT | capturing bytes, pushing a word per 4 bytes or on the final byte
// DRAIN   | all bytes captured; waiting for the FIFO to empty, then done
// -----------------------------------------------------------------------------
module iic_rd_word_packer #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 24
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    burst_len,
    iic_rd_word_packer_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [LEN_W-1:0] len_q,    len_d;
    logic [LEN_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       lane_q,   lane_d;
    logic [31:0]      pack_q,   pack_d;
    logic [3:0]       keep_q,   keep_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             done_q,   done_d;
    logic             ovf_q,    ovf_d;

    logic [31:0] fifo_data_q [DEPTH];
    logic [3:0]  fifo_keep_q [DEPTH];
    logic        fifo_last_q [DEPTH];

    logic        empty;
    logic        full;
    logic        pop;
    logic        capture;
    logic        final_byte;
    logic        push;
    logic        wr_en;
    logic [4:0]  shift;
    logic [3:0]  lane_bit;
    logic [31:0] word_next;
    logic [3:0]  keep_next;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == FULL_CNT);
        pop        = !empty && bus.word_ready;
        capture    = bus.byte_vld && bus.byte_ready && (state_q == COLLECT);
        final_byte = ((cnt_q + LEN_ONE) == len_q);

`ifdef IIC_PACK_BIG_ENDIAN_EN
        // ~lane gives 3-lane, so the shift is 24-8*lane
        shift    = {~lane_q, 3'b000};
        lane_bit = 4'b1000 >> lane_q;
`else
        shift    = {lane_q, 3'b000};
        lane_bit = 4'b0001 << lane_q;
`endif

        // Word as it stands including the byte on the bus this cycle; this is
        // what gets written when the push happens on the same edge.
        word_next = pack_q | ({24'd0, bus.byte_data} << shift);
        keep_next = keep_q | lane_bit;

        push  = capture && ((lane_q == 2'd3) || final_byte);
        // A simultaneous pop frees the slot, so a full FIFO still accepts.
        wr_en = push && (!full || pop);

        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        pack_d   = pack_q;
        keep_d   = keep_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    lane_d = '0;
                    pack_d = '0;
                    keep_d = '0;
                    ovf_d  = 1'b0;
                    if (burst_len != '0) begin
                        state_d = COLLECT;
                        len_d   = burst_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (capture) begin
                    cnt_d = cnt_q + LEN_ONE;
                    if (push) begin
                        pack_d = '0;
                        keep_d = '0;
                        lane_d = '0;
                        if (!wr_en) begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        pack_d = word_next;
                        keep_d = keep_next;
                        lane_d = lane_q + 2'd1;
                    end
                    if (final_byte) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (empty || ((count_q == CNT_ONE) && pop)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            lane_q   <= '0;
            pack_q   <= '0;
            keep_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            pack_q   <= pack_d;
            keep_q   <= keep_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; the head outputs are masked while empty instead.
    always_ff @(posedge clock) begin
        if (rst_n && wr_en) begin
            fifo_data_q[wr_ptr_q] <= word_next;
            fifo_keep_q[wr_ptr_q] <= keep_next;
            fifo_last_q[wr_ptr_q] <= final_byte;
        end
    end

    assign bus.word_vld  = !empty;
    assign bus.word_data = empty ? 32'd0 : fifo_data_q[rd_ptr_q];
    assign bus.word_keep = empty ? 4'd0  : fifo_keep_q[rd_ptr_q];
    assign bus.word_last = empty ? 1'b0  : fifo_last_q[rd_ptr_q];
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_iic_rd_word_packer.sv
module tb_iic_rd_word_packer;
    localparam int DEPTH = 8;
    localparam int LEN_W = 24;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             busy;
    logic             done;
    logic             overflow;

    iic_rd_word_packer_if bus();

    iic_rd_word_packer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .burst_len (burst_len),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    logic [7:0]  bytes_q [$];
    logic [36:0] exp_q   [$];   // {last, keep, data}
    logic [36:0] got_q   [$];

    always @(negedge clock) begin
        if (rst_n) begin
            if (bus.word_vld && bus.word_ready)
                got_q.push_back({bus.word_last, bus.word_keep, bus.word_data});
            if (done)
                done_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected words straight from the packing rules: groups of four bytes,
    // unused lanes zero, last flag on the group holding the final byte.
    function automatic void build_model();
        int n;
        n = bytes_q.size();
        exp_q.delete();
        for (int w = 0; w * 4 < n; w++) begin
            logic [31:0] d;
            logic [3:0]  k;
            logic        l;
            d = '0;
            k = '0;
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b < n) begin
`ifdef IIC_PACK_BIG_ENDIAN_EN
                    d = d | (32'(bytes_q[w * 4 + b]) << (24 - 8 * b));
                    k[3 - b] = 1'b1;
`else
                    d = d | (32'(bytes_q[w * 4 + b]) << (8 * b));
                    k[b] = 1'b1;
`endif
                end
            end
            l = (w * 4 + 4 >= n);
            exp_q.push_back({l, k, d});
        end
    endfunction

    task automatic make_bytes(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_txn(input int len);
        got_q.delete();
        done_cnt  = 0;
        start     = 1'b1;
        burst_len = LEN_W'(len);
        tick();
        start     = 1'b0;
        burst_len = LEN_W'($urandom);
    endtask

    task automatic send_bytes(input int from, input int to, input bit gaps, input bit rwr);
        for (int i = from; i < to; i++) begin
            int tries;
            int r;
            tries = 0;
            while (gaps && tries < 3 && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 2);
                bus.byte_vld   = (r == 0);
                bus.byte_ready = (r == 1);
                bus.byte_data  = 8'($urandom);
                if (rwr) bus.word_ready = 1'($urandom_range(0, 1));
                tick();
                tries++;
            end
            bus.byte_vld   = 1'b1;
            bus.byte_ready = 1'b1;
            bus.byte_data  = bytes_q[i];
            if (rwr) bus.word_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.byte_vld   = 1'b0;
        bus.byte_ready = 1'b0;
    endtask

    task automatic wait_done(input bit rwr);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 2000) begin
            tick();
            n++;
            if (done) seen = 1'b1;
            else if (rwr) bus.word_ready = 1'($urandom_range(0, 1));
        end
        check("done_seen", 64'(seen), 64'd1);
        bus.word_ready = 1'b1;
        tick();
        check("done_pulse_width", 64'(done), 64'd0);
        check("done_count", 64'(done_cnt), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic compare_words(input string tag, input int n);
        check({tag, "_count"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_word_vld"},  64'(bus.word_vld),  64'd0);
        check({tag, "_word_data"}, 64'(bus.word_data), 64'd0);
        check({tag, "_word_keep"}, 64'(bus.word_keep), 64'd0);
        check({tag, "_word_last"}, 64'(bus.word_last), 64'd0);
        check({tag, "_busy"},      64'(busy),          64'd0);
        check({tag, "_done"},      64'(done),          64'd0);
        check({tag, "_overflow"},  64'(overflow),      64'd0);
    endtask

    initial begin
        int len;
        bus.byte_vld   = 1'b0;
        bus.byte_ready = 1'b0;
        bus.byte_data  = 8'd0;
        bus.word_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // 8-byte burst, consumer always ready
        bytes_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        build_model();
        bus.word_ready = 1'b1;
        start_txn(8);
        check("burst8_busy", 64'(busy), 64'd1);
        send_bytes(0, 4, 1'b0, 1'b0);
        check("burst8_latency_vld",  64'(bus.word_vld),  64'd1);
        check("burst8_latency_data", 64'(bus.word_data), 64'(exp_q[0][31:0]));
        check("burst8_latency_keep", 64'(bus.word_keep), 64'(exp_q[0][35:32]));
        check("burst8_latency_last", 64'(bus.word_last), 64'd0);
        send_bytes(4, 8, 1'b0, 1'b0);
        wait_done(1'b0);
        compare_words("burst8", 2);

        // partial final word
        bytes_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        build_model();
        start_txn(5);
        send_bytes(0, 5, 1'b0, 1'b0);
        wait_done(1'b0);
        compare_words("partial5", 2);

        // overflow: 10 words into an 8-deep FIFO with no consumer
        make_bytes(40);
        build_model();
        bus.word_ready = 1'b0;
        start_txn(40);
        send_bytes(0, 40, 1'b1, 1'b0);
        tick();
        check("ovf_flag",     64'(overflow),     64'd1);
        check("ovf_busy",     64'(busy),         64'd1);
        check("ovf_word_vld", 64'(bus.word_vld), 64'd1);
        bus.word_ready = 1'b1;
        wait_done(1'b0);
        compare_words("overflow", 8);
        check("ovf_sticky_after_done", 64'(overflow), 64'd1);

        // handshake gating, also clears overflow on start
        bytes_q = {8'hAA};
        build_model();
        start_txn(1);
        check("ovf_cleared_by_start", 64'(overflow), 64'd0);
        bus.byte_vld   = 1'b1;
        bus.byte_ready = 1'b0;
        bus.byte_data  = 8'h55;
        repeat (3) tick();
        send_bytes(0, 1, 1'b0, 1'b0);
        wait_done(1'b0);
        compare_words("gating", 1);

        // push and pop on the same edge while full: nothing dropped
        make_bytes(36);
        build_model();
        bus.word_ready = 1'b0;
        start_txn(36);
        send_bytes(0, 35, 1'b0, 1'b0);
        bus.word_ready = 1'b1;
        bus.byte_vld   = 1'b1;
        bus.byte_ready = 1'b1;
        bus.byte_data  = bytes_q[35];
        tick();
        bus.byte_vld   = 1'b0;
        bus.byte_ready = 1'b0;
        wait_done(1'b0);
        compare_words("full_pushpop", 9);
        check("full_pushpop_ovf", 64'(overflow), 64'd0);

        // zero length
        got_q.delete();
        done_cnt  = 0;
        start     = 1'b1;
        burst_len = '0;
        tick();
        start = 1'b0;
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        tick();
        check("zero_done_clear", 64'(done),          64'd0);
        check("zero_no_word",    64'(bus.word_vld),  64'd0);
        check("zero_busy_after", 64'(busy),          64'd0);
        check("zero_done_count", 64'(done_cnt),      64'd1);
        check("zero_pops",       64'(got_q.size()),  64'd0);

        // start during COLLECT is ignored
        make_bytes(6);
        build_model();
        start_txn(6);
        send_bytes(0, 3, 1'b0, 1'b0);
        start     = 1'b1;
        burst_len = LEN_W'(2);
        tick();
        start = 1'b0;
        send_bytes(3, 6, 1'b0, 1'b0);
        wait_done(1'b0);
        compare_words("ignored_start", 2);

        // reset with 2 buffered words and 3 captured bytes
        make_bytes(20);
        bus.word_ready = 1'b0;
        start_txn(20);
        send_bytes(0, 11, 1'b0, 1'b0);
        check("midrst_pre_vld",  64'(bus.word_vld), 64'd1);
        check("midrst_pre_busy", 64'(busy),         64'd1);
        rst_n = 1'b0;
        tick();
        check_outputs_zero("midrst");
        rst_n = 1'b1;
        tick();
        make_bytes(4);
        build_model();
        bus.word_ready = 1'b1;
        start_txn(4);
        send_bytes(0, 4, 1'b0, 1'b0);
        wait_done(1'b0);
        compare_words("after_reset", 1);

        // randomized bursts that fit the FIFO, random gaps and back-pressure
        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(1, 32);
            make_bytes(len);
            build_model();
            bus.word_ready = 1'($urandom_range(0, 1));
            start_txn(len);
            send_bytes(0, len, 1'b1, 1'b1);
            wait_done(1'b1);
            compare_words($sformatf("rand%0d", t), exp_q.size());
            check($sformatf("rand%0d_ovf", t), 64'(overflow), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
